config_loader: RTL and testbench

CONFIG_LOADER -- requirements
Module: config_loader

---
 rtl/config_loader.sv | 211 +++++++++++++++++++++
 tb/tb_config_loader.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_loader.sv
// Configuration shift-chain loader with optional CRC-16 readback verification.
// Streams bitstream words MSB first into a fabric chain using a two-phase serial clock.
module config_loader #(
  parameter  int CONFIG_WIDTH = 7493,
  parameter  int WORD_WIDTH   = 32,
  localparam int NUM_WORDS    = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH,
  localparam int BC_W         = $clog2(CONFIG_WIDTH + 1),
  localparam int WB_W         = $clog2(WORD_WIDTH + 1),
  localparam int WN_W         = $clog2(NUM_WORDS + 1)
) (
  input  logic                  clk,
  input  logic                  sys_reset,
  input  logic                  start,
  input  logic                  verify,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  config_in,
  output logic                  config_clk,
  output logic                  config_en,
  input  logic                  config_out,
  output logic                  fabric_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [BC_W-1:0]       bit_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_READBACK,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'h1021;

  state_t                r_state;
  state_t                w_next;
  logic                  r_verify;
  logic [WORD_WIDTH-1:0] r_buf;
  logic                  r_full;
  logic [WB_W-1:0]       r_wbit;
  logic [WN_W-1:0]       r_words;
  logic [BC_W-1:0]       r_bit_cnt;
  logic                  r_cfg_in;
  logic                  r_cfg_clk;
  logic [15:0]           r_crc;
  logic [15:0]           r_crc_ref;

  logic                  w_start;
  logic                  w_active;
  logic                  w_ready;
  logic                  w_word_end;
  logic                  w_pass_end;
  logic                  w_crc_bit;
  logic                  w_crc_fb;
  logic [15:0]           w_crc_next;
  logic [WORD_WIDTH-1:0] w_buf_sh;

  assign w_start  = start &&
                    ((r_state == S_IDLE) ||
                     (r_state == S_DONE) ||
                     (r_state == S_ERROR));
  assign w_active = (r_state == S_LOAD) ||
                    (r_state == S_READBACK);
  assign w_ready  = w_active && !r_full &&
                    (r_words < WN_W'(NUM_WORDS));

  // Word boundary or chain length reached, seen in phase 1 after the count step
  assign w_word_end = (r_wbit == WB_W'(WORD_WIDTH)) ||
                      (r_bit_cnt == BC_W'(CONFIG_WIDTH));
  assign w_pass_end = w_active && r_full && r_cfg_clk &&
                      (r_bit_cnt == BC_W'(CONFIG_WIDTH));

  // Readback folds the chain tail, load folds the driven bit
  assign w_crc_bit  = (r_state == S_READBACK) ? config_out : r_cfg_in;
  assign w_crc_fb   = r_crc[15] ^ w_crc_bit;
  assign w_crc_next = {r_crc[14:0], 1'b0} ^ (w_crc_fb ? CRC_POLY : 16'h0000);
  assign w_buf_sh   = r_buf << 1;

  // FSM state register
  always_ff @(posedge clk or negedge sys_reset) begin
    if (!sys_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state decision
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (w_start) begin
          w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_pass_end) begin
          w_next = r_verify ? S_READBACK : S_DONE;
        end
      end
      S_READBACK: begin
        if (w_pass_end) begin
          w_next = S_CHECK;
        end
      end
      S_CHECK: begin
        w_next = (r_crc == r_crc_ref) ? S_DONE : S_ERROR;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Word buffer, two-phase bit shifter, counters and CRC
  always_ff @(posedge clk or negedge sys_reset) begin
    if (!sys_reset) begin
      r_verify  <= 1'b0;
      r_buf     <= '0;
      r_full    <= 1'b0;
      r_wbit    <= '0;
      r_words   <= '0;
      r_bit_cnt <= '0;
      r_cfg_in  <= 1'b0;
      r_cfg_clk <= 1'b0;
      r_crc     <= CRC_INIT;
      r_crc_ref <= CRC_INIT;
    end else if (w_start) begin
      r_verify  <= verify;
      r_full    <= 1'b0;
      r_wbit    <= '0;
      r_words   <= '0;
      r_bit_cnt <= '0;
      r_cfg_in  <= 1'b0;
      r_cfg_clk <= 1'b0;
      r_crc     <= CRC_INIT;
    end else if (w_active) begin
      if (!r_full) begin
        if (word_valid && w_ready) begin
          r_buf    <= word_data;
          r_full   <= 1'b1;
          r_wbit   <= '0;
          r_words  <= r_words + WN_W'(1);
          r_cfg_in <= word_data[WORD_WIDTH-1];
        end
      end else if (!r_cfg_clk) begin
        r_cfg_clk <= 1'b1;
        r_bit_cnt <= r_bit_cnt + BC_W'(1);
        r_wbit    <= r_wbit + WB_W'(1);
        r_crc     <= w_crc_next;
      end else begin
        r_cfg_clk <= 1'b0;
        if (w_word_end) begin
          r_full <= 1'b0;
        end else begin
          r_buf    <= w_buf_sh;
          r_cfg_in <= w_buf_sh[WORD_WIDTH-1];
        end
        if (w_pass_end && (r_state == S_LOAD)) begin
          r_crc_ref <= r_crc;
          if (r_verify) begin
            r_crc     <= CRC_INIT;
            r_bit_cnt <= '0;
            r_words   <= '0;
          end
        end
      end
    end
  end

  // Status and chain control decoded from state
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    fabric_rst = 1'b1;
    config_en  = 1'b0;
    unique case (r_state)
      S_LOAD, S_READBACK: begin
        busy      = 1'b1;
        config_en = 1'b1;
      end
      S_CHECK: begin
        busy = 1'b1;
      end
      S_DONE: begin
        done       = 1'b1;
        fabric_rst = 1'b0;
      end
      S_ERROR: begin
        error = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign word_ready = w_ready;
  assign config_in  = r_cfg_in;
  assign config_clk = r_cfg_clk;
  assign bit_count  = r_bit_cnt;

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader with a 40-bit behavioural fabric chain.
// Expected chain, timing and verify outcome come from a word/CRC model.
module tb_config_loader;

  localparam int CW = 40;
  localparam int WW = 16;

  logic        clk = 1'b0;
  logic        sys_reset = 1'b1;
  logic        start = 1'b0;
  logic        verify = 1'b0;
  logic [15:0] word_data = '0;
  logic        word_valid = 1'b0;
  logic        word_ready;
  logic        config_in;
  logic        config_clk;
  logic        config_en;
  logic        config_out;
  logic        fabric_rst;
  logic        busy;
  logic        done;
  logic        error;
  logic [5:0]  bit_count;

  int checks = 0;
  int errors = 0;

  logic [39:0] chain = '0;
  int          rises = 0;
  int          flip_base = 0;
  int          flip_bit = -1;

  config_loader #(
    .CONFIG_WIDTH(CW),
    .WORD_WIDTH  (WW)
  ) dut (
    .clk       (clk),
    .sys_reset (sys_reset),
    .start     (start),
    .verify    (verify),
    .word_data (word_data),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .config_in (config_in),
    .config_clk(config_clk),
    .config_en (config_en),
    .config_out(config_out),
    .fabric_rst(fabric_rst),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .bit_count (bit_count)
  );

  always #5 clk = ~clk;

  assign config_out = chain[39];

  // Fabric chain: shifts on config_clk rise; optional upset after the load pass
  always @(posedge config_clk) begin
    logic [39:0] nx;
    nx = {chain[38:0], config_in};
    if (flip_bit >= 0 && (rises - flip_base) == CW - 1)
      nx[flip_bit] = ~nx[flip_bit];
    chain <= nx;
    rises <= rises + 1;
  end

  function automatic logic [15:0] crc16(input logic [39:0] s);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = CW - 1; i >= 0; i--) begin
      if (c[15] ^ s[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [39:0] stream(input logic [15:0] a,
                                         input logic [15:0] b,
                                         input logic [15:0] c);
    logic [47:0] cat;
    cat = {a, b, c};
    return cat[47:8];
  endfunction

  task automatic run_seq(input logic vfy, input logic [15:0] w0,
                         input logic [15:0] w1, input logic [15:0] w2,
                         input int stall_idx, input int stall_len,
                         input int fbit, input int start_at,
                         output int cyc);
    logic [15:0] wq [3];
    int nw;
    wq[0] = w0;
    wq[1] = w1;
    wq[2] = w2;
    nw = vfy ? 6 : 3;
    flip_base = rises;
    flip_bit = fbit;
    cyc = -1;
    @(negedge clk);
    start = 1'b1;
    verify = vfy;
    @(posedge clk);
    fork
      begin
        int idx, st, g;
        idx = 0;
        st = 0;
        g = 0;
        @(negedge clk);
        start = 1'b0;
        verify = 1'b0;
        while (idx < nw && g < 400) begin
          word_data = wq[idx % 3];
          word_valid = !(idx == stall_idx && st < stall_len);
          start = (g == start_at);
          #1;
          if (word_ready && !word_valid) begin
            st++;
            checks++;
            if (config_clk !== 1'b0 || config_en !== 1'b1) begin
              errors++;
              $display("FAIL stall: clk=%b en=%b required clk=0 en=1",
                       config_clk, config_en);
            end
          end
          if (word_ready && word_valid) idx++;
          @(negedge clk);
          g++;
        end
        word_valid = 1'b0;
        start = 1'b0;
      end
      begin
        int prev;
        prev = 0;
        for (int n = 1; n <= 400; n++) begin
          @(posedge clk);
          #1;
          if (!vfy) begin
            checks++;
            if (int'(bit_count) < prev) begin
              errors++;
              $display("FAIL bit_count_mono: got %0d after %0d", bit_count, prev);
            end
            prev = int'(bit_count);
          end
          if (done || error) begin
            cyc = n;
            break;
          end
        end
      end
    join
    flip_bit = -1;
    checks++;
    if (cyc < 0) begin
      errors++;
      $display("FAIL timeout: no done/error within 400 cycles");
    end
  endtask

  task automatic test_reset();
    #3 sys_reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({config_clk, config_en, config_in, word_ready, busy, done, error,
         fabric_rst} !== 8'b0000_0001) begin
      errors++;
      $display("FAIL reset_flags: got %b required 00000001",
               {config_clk, config_en, config_in, word_ready, busy, done,
                error, fabric_rst});
    end
    checks++;
    if (bit_count !== 6'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d required 0", bit_count);
    end
    sys_reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_load_only();
    int cyc, base;
    base = rises;
    run_seq(1'b0, 16'hA5C3, 16'h0F0F, 16'hFF00, -1, 0, -1, -1, cyc);
    checks++;
    if (cyc !== 83) begin
      errors++;
      $display("FAIL load_cycles: got %0d required 83", cyc);
    end
    checks++;
    if (chain !== 40'hA5C30F0FFF) begin
      errors++;
      $display("FAIL load_chain: got %h required a5c30f0fff", chain);
    end
    checks++;
    if ({done, error, fabric_rst, busy} !== 4'b1000) begin
      errors++;
      $display("FAIL load_flags: got %b required 1000",
               {done, error, fabric_rst, busy});
    end
    checks++;
    if (bit_count !== 6'd40 || rises - base !== 40) begin
      errors++;
      $display("FAIL load_bits: got cnt=%0d rises=%0d required 40/40",
               bit_count, rises - base);
    end
  endtask

  task automatic test_verify_pass();
    int cyc, base;
    base = rises;
    run_seq(1'b1, 16'hA5C3, 16'h0F0F, 16'hFF00, -1, 0, -1, -1, cyc);
    checks++;
    if (cyc !== 167) begin
      errors++;
      $display("FAIL verify_cycles: got %0d required 167", cyc);
    end
    checks++;
    if ({done, error, fabric_rst} !== 3'b100) begin
      errors++;
      $display("FAIL verify_flags: got %b required 100",
               {done, error, fabric_rst});
    end
    checks++;
    if (chain !== 40'hA5C30F0FFF || rises - base !== 80) begin
      errors++;
      $display("FAIL verify_chain: got %h rises=%0d required a5c30f0fff/80",
               chain, rises - base);
    end
  endtask

  task automatic test_verify_flip();
    int cyc;
    run_seq(1'b1, 16'hA5C3, 16'h0F0F, 16'hFF00, -1, 0, 13, -1, cyc);
    checks++;
    if (cyc !== 167) begin
      errors++;
      $display("FAIL flip_cycles: got %0d required 167", cyc);
    end
    checks++;
    if ({done, error, fabric_rst, busy} !== 4'b0110) begin
      errors++;
      $display("FAIL flip_flags: got %b required 0110",
               {done, error, fabric_rst, busy});
    end
  endtask

  task automatic test_stall();
    int cyc;
    run_seq(1'b0, 16'hA5C3, 16'h0F0F, 16'hFF00, 1, 10, -1, -1, cyc);
    checks++;
    if (cyc !== 93) begin
      errors++;
      $display("FAIL stall_cycles: got %0d required 93", cyc);
    end
    checks++;
    if (chain !== 40'hA5C30F0FFF || done !== 1'b1) begin
      errors++;
      $display("FAIL stall_chain: got %h done=%b required a5c30f0fff/1",
               chain, done);
    end
  endtask

  task automatic test_reset_mid_pass();
    logic [15:0] wq [3];
    int base, idx, g, r0, cyc;
    wq[0] = 16'h1234;
    wq[1] = 16'h5678;
    wq[2] = 16'h9ABC;
    base = rises;
    idx = 0;
    g = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while ((rises - base) < 17 && g < 200) begin
      word_data = wq[idx % 3];
      word_valid = 1'b1;
      #1;
      if (word_ready) idx++;
      @(negedge clk);
      g++;
    end
    checks++;
    if (g >= 200) begin
      errors++;
      $display("FAIL midrst_reach: got %0d rises required 17", rises - base);
    end
    #2 sys_reset = 1'b0;
    #1;
    checks++;
    if ({config_clk, config_en, config_in, word_ready, busy, done, error,
         fabric_rst} !== 8'b0000_0001 || bit_count !== 6'd0) begin
      errors++;
      $display("FAIL midrst_async: got %b cnt=%0d required 00000001/0",
               {config_clk, config_en, config_in, word_ready, busy, done,
                error, fabric_rst}, bit_count);
    end
    r0 = rises;
    word_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (rises !== r0) begin
      errors++;
      $display("FAIL midrst_edges: got %0d extra rises required 0", rises - r0);
    end
    sys_reset = 1'b1;
    @(negedge clk);
    run_seq(1'b0, 16'hC0DE, 16'hBEEF, 16'h7700, -1, 0, -1, -1, cyc);
    checks++;
    if (chain !== 40'hC0DEBEEF77 || cyc !== 83 || done !== 1'b1) begin
      errors++;
      $display("FAIL midrst_reload: got %h cyc=%0d done=%b required c0debeef77/83/1",
               chain, cyc, done);
    end
  endtask

  task automatic test_start_during_load();
    int cyc;
    run_seq(1'b0, 16'h0001, 16'h8000, 16'h5A00, -1, 0, -1, 30, cyc);
    checks++;
    if (cyc !== 83 || chain !== 40'h000180005A || done !== 1'b1) begin
      errors++;
      $display("FAIL start_ignored: got %h cyc=%0d done=%b required 000180005a/83/1",
               chain, cyc, done);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      logic [15:0] w0, w1, w2;
      logic        vfy, exp_err;
      logic [39:0] exp_chain, rb;
      int sidx, slen, fb, cyc, exp_cyc;
      w0 = 16'($urandom);
      w1 = 16'($urandom);
      w2 = 16'($urandom);
      vfy = 1'($urandom_range(0, 1));
      sidx = $urandom_range(0, 2);
      slen = $urandom_range(0, 5);
      fb = (vfy && $urandom_range(0, 1) == 1) ? $urandom_range(0, CW - 1) : -1;
      exp_chain = stream(w0, w1, w2);
      rb = exp_chain;
      if (fb >= 0) rb[fb] = ~rb[fb];
      exp_err = vfy && (crc16(exp_chain) != crc16(rb));
      exp_cyc = (vfy ? 2 * (2 * CW + 3) + 1 : 2 * CW + 3) + slen;
      run_seq(vfy, w0, w1, w2, sidx, slen, fb, -1, cyc);
      checks++;
      if (cyc !== exp_cyc) begin
        errors++;
        $display("FAIL rnd%0d_cycles: got %0d required %0d", it, cyc, exp_cyc);
      end
      checks++;
      if ({done, error, fabric_rst} !== {!exp_err, exp_err, exp_err}) begin
        errors++;
        $display("FAIL rnd%0d_flags: got %b required %b", it,
                 {done, error, fabric_rst}, {!exp_err, exp_err, exp_err});
      end
      if (fb < 0) begin
        checks++;
        if (chain !== exp_chain) begin
          errors++;
          $display("FAIL rnd%0d_chain: got %h required %h", it, chain, exp_chain);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_only();
    test_verify_pass();
    test_verify_flip();
    test_stall();
    test_reset_mid_pass();
    test_start_during_load();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
